// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_BOUNDS  = 2'b10;

    localparam logic [31:0] TEXT_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] TEXT_LIMIT_DEF = 32'h0000_4000;
    localparam logic [29:0] NPC_RESET      = 30'h0C00;

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction memory req/ack bus between fetch unit and memory
interface ifetch_unit_if;
    logic        req;
    logic [29:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifetch_wdog.sv
// rtl/ifetch_wdog.sv - wait-state watchdog; expired fires on the TIMEOUT-th counted cycle, 0 disables
module ifetch_wdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            logic [W-1:0] count_q;

            always_ff @(posedge clk) begin
                if (!rst || clear) begin
                    count_q <= '0;
                end else if (count_en) begin
                    count_q <= count_q + W'(1);
                end
            end

            // Combine with count_en so the cycle that would reach TIMEOUT is the one that fires
            assign expired = count_en && (count_q == W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch sequencer; optional text-segment check via IFETCH_BOUNDS_CHK_EN
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
`ifdef IFETCH_BOUNDS_CHK_EN
    ,
    parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEF,
    parameter logic [31:0] TEXT_LIMIT = TEXT_LIMIT_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [29:0]          pc,
    input  logic                 fetch_start,
    input  logic                 fault_clr,
    ifetch_unit_if.master        imem,
    output logic [31:0]          ir,
    output logic [29:0]          npc,
    output logic                 pc_wr,
    output logic                 fetch_done,
    output logic                 busy,
    output logic                 fault,
    output logic [1:0]           fault_cause
);

    state_e      state_q;
    logic [29:0] pc_q;
    logic [29:0] imem_addr_q;
    logic        imem_req_q;
    logic [31:0] ir_q;
    logic [29:0] npc_q;
    logic        pc_wr_q;
    logic        fetch_done_q;
    logic [1:0]  fault_cause_q;
    logic        bounds_ok;
    logic        wdog_expired;

`ifdef IFETCH_BOUNDS_CHK_EN
    logic [31:0] pc_byte;
    assign pc_byte   = {pc, 2'b00};
    assign bounds_ok = (pc_byte >= TEXT_BASE) && (pc_byte < TEXT_LIMIT);
`else
    assign bounds_ok = 1'b1;
`endif

    ifetch_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != S_WAIT),
        .count_en ((state_q == S_WAIT) && !imem.ack),
        .expired  (wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            imem_addr_q   <= '0;
            imem_req_q    <= 1'b0;
            ir_q          <= 32'h0000_0000;
            npc_q         <= NPC_RESET;
            pc_wr_q       <= 1'b0;
            fetch_done_q  <= 1'b0;
            fault_cause_q <= FC_NONE;
        end else begin
            pc_wr_q      <= 1'b0;
            fetch_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fetch_start) begin
                        if (bounds_ok) begin
                            pc_q        <= pc;
                            imem_addr_q <= pc;
                            imem_req_q  <= 1'b1;
                            state_q     <= S_WAIT;
                        end else begin
                            fault_cause_q <= FC_BOUNDS;
                            state_q       <= S_FAULT;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack has priority over a watchdog expiry in the same cycle
                    if (imem.ack) begin
                        ir_q         <= imem.rdata;
                        npc_q        <= pc_q + 30'd1;
                        imem_req_q   <= 1'b0;
                        pc_wr_q      <= 1'b1;
                        fetch_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (wdog_expired) begin
                        imem_req_q    <= 1'b0;
                        fault_cause_q <= FC_TIMEOUT;
                        state_q       <= S_FAULT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        fault_cause_q <= FC_NONE;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem.req    = imem_req_q;
    assign imem.addr   = imem_addr_q;
    assign ir          = ir_q;
    assign npc         = npc_q;
    assign pc_wr       = pc_wr_q;
    assign fetch_done  = fetch_done_q;
    assign busy        = (state_q == S_WAIT) || (state_q == S_DONE);
    assign fault       = (state_q == S_FAULT);
    assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
`timescale 1ns/1ps
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [29:0] pc;
    logic        fetch_start;
    logic        fault_clr;
    logic [31:0] ir;
    logic [29:0] npc;
    logic        pc_wr;
    logic        fetch_done;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;

    int checks   = 0;
    int failures = 0;

    ifetch_unit_if imem_bus ();

    ifetch_unit #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_start (fetch_start),
        .fault_clr   (fault_clr),
        .imem        (imem_bus.master),
        .ir          (ir),
        .npc         (npc),
        .pc_wr       (pc_wr),
        .fetch_done  (fetch_done),
        .busy        (busy),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        pc = '0;
        fetch_start = 1'b0;
        fault_clr = 1'b0;
        imem_bus.ack = 1'b0;
        imem_bus.rdata = '0;

        // Reset
        tick();
        tick();
        check("rst_ir", ir, 32'h0);
        check("rst_npc", 32'(npc), 32'h0C00);
        check("rst_req", 32'(imem_bus.req), 32'h0);
        check("rst_addr", 32'(imem_bus.addr), 32'h0);
        check("rst_pc_wr", 32'(pc_wr), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_cause", 32'(fault_cause), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick();

        // Single-cycle ack fetch
        pc = 30'h0C00;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("f1_req", 32'(imem_bus.req), 32'h1);
        check("f1_addr", 32'(imem_bus.addr), 32'h0C00);
        check("f1_busy", 32'(busy), 32'h1);
        check("f1_pc_wr_early", 32'(pc_wr), 32'h0);
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'h2008_0005;
        tick();
        imem_bus.ack = 1'b0;
        imem_bus.rdata = 32'hDEAD_BEEF;
        check("f1_pc_wr", 32'(pc_wr), 32'h1);
        check("f1_done", 32'(fetch_done), 32'h1);
        check("f1_ir", ir, 32'h2008_0005);
        check("f1_npc", 32'(npc), 32'h0C01);
        check("f1_req_drop", 32'(imem_bus.req), 32'h0);
        tick();
        check("f1_pc_wr_once", 32'(pc_wr), 32'h0);
        check("f1_done_once", 32'(fetch_done), 32'h0);
        check("f1_idle", 32'(busy), 32'h0);

        // Ack delayed five cycles, fetch_start re-pulsed while waiting
        pc = 30'h0C01;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("f2_req_hold%0d", i), 32'(imem_bus.req), 32'h1);
            check($sformatf("f2_no_pc_wr%0d", i), 32'(pc_wr), 32'h0);
            fetch_start = (i == 2);
            pc = 30'h0ABC;
            tick();
        end
        fetch_start = 1'b0;
        check("f2_req_hold5", 32'(imem_bus.req), 32'h1);
        check("f2_addr_stable", 32'(imem_bus.addr), 32'h0C01);
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'h8C09_0004;
        tick();
        imem_bus.ack = 1'b0;
        check("f2_pc_wr", 32'(pc_wr), 32'h1);
        check("f2_ir", ir, 32'h8C09_0004);
        check("f2_npc", 32'(npc), 32'h0C02);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("f2_no_second_req%0d", i), 32'(imem_bus.req), 32'h0);
            check($sformatf("f2_no_second_wr%0d", i), 32'(pc_wr), 32'h0);
        end

        // Watchdog timeout: ack never arrives
        pc = 30'h0D00;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("to_req%0d", i), 32'(imem_bus.req), 32'h1);
            tick();
        end
        check("to_req_last", 32'(imem_bus.req), 32'h1);
        check("to_no_fault_yet", 32'(fault), 32'h0);
        tick();
        check("to_fault", 32'(fault), 32'h1);
        check("to_cause", 32'(fault_cause), 32'h1);
        check("to_req_drop", 32'(imem_bus.req), 32'h0);
        check("to_no_pc_wr", 32'(pc_wr), 32'h0);
        check("to_ir_kept", ir, 32'h8C09_0004);
        check("to_npc_kept", 32'(npc), 32'h0C02);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("to_start_ignored", 32'(imem_bus.req), 32'h0);
        check("to_still_fault", 32'(fault), 32'h1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_fault", 32'(fault), 32'h0);
        check("clr_cause", 32'(fault_cause), 32'h0);
        check("clr_busy", 32'(busy), 32'h0);

`ifndef IFETCH_BOUNDS_CHK_EN
        // Top-of-space wrap
        pc = 30'h3FFF_FFFF;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("wrap_addr", 32'(imem_bus.addr), 32'h3FFF_FFFF);
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'h0000_0020;
        tick();
        imem_bus.ack = 1'b0;
        check("wrap_npc", 32'(npc), 32'h0);
        check("wrap_ir", ir, 32'h0000_0020);
        tick();
`endif

        // Byte address 0x4000, just past the text segment
        pc = 30'h1000;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
`ifdef IFETCH_BOUNDS_CHK_EN
        check("oob_no_req", 32'(imem_bus.req), 32'h0);
        check("oob_fault", 32'(fault), 32'h1);
        check("oob_cause", 32'(fault_cause), 32'h2);
        check("oob_npc_kept", 32'(npc), 32'h0C02);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("oob_clr", 32'(fault), 32'h0);
`else
        check("nochk_req", 32'(imem_bus.req), 32'h1);
        check("nochk_addr", 32'(imem_bus.addr), 32'h1000);
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'h1234_5678;
        tick();
        imem_bus.ack = 1'b0;
        check("nochk_npc", 32'(npc), 32'h1001);
        check("nochk_cause", 32'(fault_cause), 32'h0);
        tick();
`endif

        // Reset mid-transaction, late ack ignored
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pc = 30'h0C10;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("mr_req", 32'(imem_bus.req), 32'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mr_req_drop", 32'(imem_bus.req), 32'h0);
        check("mr_idle", 32'(busy), 32'h0);
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'hFFFF_FFFF;
        tick();
        imem_bus.ack = 1'b0;
        check("mr_no_pc_wr", 32'(pc_wr), 32'h0);
        check("mr_ir", ir, 32'h0);
        check("mr_npc", 32'(npc), 32'h0C00);
        check("mr_still_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
